pipeline_stall_ctrl: RTL and testbench

// - Consumer of the hazard unit's stall_load. Also takes memory wait and branch-redirect events.
// - Outputs per-stage load enables, the ID/EX bubble and flush strobes for the 5-stage LC-3b pipeline.
// - Sits beside the hazard unit in the top-level datapath. Owns every pipeline-register enable.

---
 rtl/pipeline_stall_ctrl_pkg.sv | 46 ++++
 rtl/pipeline_stall_ctrl_if.sv | 34 +++
 rtl/pipeline_stall_ctrl_perf.sv | 30 +++
 rtl/pipeline_stall_ctrl.sv | 78 +++++++
 tb/tb_pipeline_stall_ctrl.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared LC-3b stall-control types: FSM state, stall cause and the per-cause control word.
// Controller outputs are a pure lookup on the resolved cause (plus reset), kept here so all users agree.
package pipeline_stall_ctrl_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    BUBBLED = 1'b1
  } lc3b_stall_state;

  typedef enum logic [2:0] {
    sc_none,
    sc_dmem,
    sc_redirect,
    sc_load_use,
    sc_imem
  } lc3b_stall_cause;

  typedef struct packed {
    logic load_pc;
    logic load_if_id;
    logic load_id_ex;
    logic load_ex_mem;
    logic load_mem_wb;
    logic bubble_id_ex;
    logic flush_if_id;
    logic flush_ex_mem;
  } lc3b_stall_ctl_t;

  localparam lc3b_stall_ctl_t CTL_RUN      = 8'b11111_000;
  localparam lc3b_stall_ctl_t CTL_FREEZE   = 8'b00000_000;
  localparam lc3b_stall_ctl_t CTL_REDIRECT = 8'b11111_111;
  localparam lc3b_stall_ctl_t CTL_BUBBLE   = 8'b00111_100;
  localparam lc3b_stall_ctl_t CTL_RESET    = 8'b00000_111;

  // Load-use and fetch-wait share a control word; they differ only in the next state.
  function automatic lc3b_stall_ctl_t cause_ctl(input lc3b_stall_cause cause);
    case (cause)
      sc_dmem:     cause_ctl = CTL_FREEZE;
      sc_redirect: cause_ctl = CTL_REDIRECT;
      sc_load_use: cause_ctl = CTL_BUBBLE;
      sc_imem:     cause_ctl = CTL_BUBBLE;
      default:     cause_ctl = CTL_RUN;
    endcase
  endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Handshake bundle between the stall controller (slave) and the datapath/hazard side (master).
// Carries the stall/wait/redirect requests, the pipeline-register enables and the perf counters.
interface pipeline_stall_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             stall_load;
  logic             imem_read;
  logic             imem_resp;
  logic             dmem_req;
  logic             dmem_resp;
  logic             branch_taken;
  logic             load_pc;
  logic             load_if_id;
  logic             load_id_ex;
  logic             load_ex_mem;
  logic             load_mem_wb;
  logic             bubble_id_ex;
  logic             flush_if_id;
  logic             flush_ex_mem;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output stall_load, imem_read, imem_resp, dmem_req, dmem_resp, branch_taken,
    input  load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
    input  bubble_id_ex, flush_if_id, flush_ex_mem, stall_cycles, flush_count
  );

  modport slave (
    input  stall_load, imem_read, imem_resp, dmem_req, dmem_resp, branch_taken,
    output load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
    output bubble_id_ex, flush_if_id, flush_ex_mem, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_stall_ctrl_perf.sv
// Pipeline performance counters: frozen-PC cycles and taken-branch flushes, both wrapping.
// Instantiated by pipeline_stall_ctrl only when PIPE_PERF_CNT_EN is defined.
module pipe_perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_stall,
  input  logic             i_redirect,
  output logic [CNT_W-1:0] o_stall_cycles,
  output logic [CNT_W-1:0] o_flush_count
);

  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (i_stall)    r_stall_cycles <= r_stall_cycles + 1'b1;
      if (i_redirect) r_flush_count  <= r_flush_count + 1'b1;
    end
  end

  assign o_stall_cycles = r_stall_cycles;
  assign o_flush_count  = r_flush_count;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// LC-3b 5-stage stall/flush controller: owns every pipeline-register enable; outputs are combinational.
// Optional perf counters under macro PIPE_PERF_CNT_EN; otherwise counter outputs are tied to zero.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input logic                clk,
  input logic                rst,
  pipeline_stall_ctrl_if.slave bus
);

  logic            w_dwait;
  logic            w_iwait;
  lc3b_stall_state r_state;
  lc3b_stall_state w_next_state;
  lc3b_stall_cause w_cause;
  lc3b_stall_ctl_t w_ctl;

  assign w_dwait = bus.dmem_req & ~bus.dmem_resp;
  assign w_iwait = bus.imem_read & ~bus.imem_resp;

  // sc_dmem stands for any full freeze, including a branch waiting on an outstanding fetch.
  always_comb begin
    w_cause = sc_none;
    if (w_dwait || (bus.branch_taken && w_iwait)) begin
      w_cause = sc_dmem;
    end else if (bus.branch_taken) begin
      w_cause = sc_redirect;
    end else if (bus.stall_load && (r_state == RUN)) begin
      w_cause = sc_load_use;
    end else if (w_iwait) begin
      w_cause = sc_imem;
    end
  end

  always_comb begin
    w_next_state = RUN;
    case (w_cause)
      sc_dmem:     w_next_state = r_state;
      sc_load_use: w_next_state = BUBBLED;
      default:     w_next_state = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_next_state;
  end

  assign w_ctl = rst ? CTL_RESET : cause_ctl(w_cause);

  assign bus.load_pc      = w_ctl.load_pc;
  assign bus.load_if_id   = w_ctl.load_if_id;
  assign bus.load_id_ex   = w_ctl.load_id_ex;
  assign bus.load_ex_mem  = w_ctl.load_ex_mem;
  assign bus.load_mem_wb  = w_ctl.load_mem_wb;
  assign bus.bubble_id_ex = w_ctl.bubble_id_ex;
  assign bus.flush_if_id  = w_ctl.flush_if_id;
  assign bus.flush_ex_mem = w_ctl.flush_ex_mem;

`ifdef PIPE_PERF_CNT_EN
  pipe_perf_counter #(
    .CNT_W (CNT_W)
  ) u_perf (
    .clk            (clk),
    .rst            (rst),
    .i_stall        (~w_ctl.load_pc),
    .i_redirect     (w_cause == sc_redirect),
    .o_stall_cycles (bus.stall_cycles),
    .o_flush_count  (bus.flush_count)
  );
`else
  assign bus.stall_cycles = {CNT_W{1'b0}};
  assign bus.flush_count  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl; control word order is pc,if_id,id_ex,ex_mem,mem_wb,bubble,flush_if_id,flush_ex_mem.
module tb_pipeline_stall_ctrl;

`ifdef PIPE_PERF_CNT_EN
  localparam int W = 4;
`else
  localparam int W = 32;
`endif

  localparam logic [7:0] E_RUN    = 8'b11111_000;
  localparam logic [7:0] E_FREEZE = 8'b00000_000;
  localparam logic [7:0] E_REDIR  = 8'b11111_111;
  localparam logic [7:0] E_BUBBLE = 8'b00111_100;
  localparam logic [7:0] E_RESET  = 8'b00000_111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] obs;

  pipeline_stall_ctrl_if #(.CNT_W(W)) bus ();

  pipeline_stall_ctrl #(.CNT_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign obs = {bus.load_pc, bus.load_if_id, bus.load_id_ex, bus.load_ex_mem, bus.load_mem_wb,
                bus.bubble_id_ex, bus.flush_if_id, bus.flush_ex_mem};

  task automatic drive(input logic sl, input logic ir, input logic irs,
                       input logic dq, input logic ds, input logic bt);
    bus.stall_load   = sl;
    bus.imem_read    = ir;
    bus.imem_resp    = irs;
    bus.dmem_req     = dq;
    bus.dmem_resp    = ds;
    bus.branch_taken = bt;
  endtask

  // Advance to just after the next rising edge; inputs are then driven and outputs sampled 2 ns later.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    drive(0, 0, 0, 0, 0, 0);
    #3;
    checks++;
    if (obs !== E_RESET) begin errors++; $display("FAIL reset_ctl got=%b exp=%b", obs, E_RESET); end
    checks++;
    if (bus.stall_cycles !== '0 || bus.flush_count !== '0) begin
      errors++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", bus.stall_cycles, bus.flush_count);
    end
    tick;
    rst = 1'b0;
    #2;
    checks++;
    if (obs !== E_RUN) begin errors++; $display("FAIL reset_idle got=%b exp=%b", obs, E_RUN); end
  endtask

  task automatic test_load_use;
    tick; drive(1, 0, 0, 0, 0, 0); #2;
    checks++;
    if (obs !== E_BUBBLE) begin errors++; $display("FAIL t1_lu got=%b exp=%b", obs, E_BUBBLE); end
    tick; drive(1, 0, 0, 0, 0, 0); #2;
    checks++;
    if (obs !== E_RUN) begin errors++; $display("FAIL t1_masked got=%b exp=%b", obs, E_RUN); end
    tick; drive(0, 0, 0, 0, 0, 0); #2;
    checks++;
    if (obs !== E_RUN) begin errors++; $display("FAIL t1_run got=%b exp=%b", obs, E_RUN); end
  endtask

  task automatic test_dmem_freeze;
    for (int i = 0; i < 4; i++) begin
      tick; drive(1, 0, 0, 1, 0, 0); #2;
      checks++;
      if (obs !== E_FREEZE) begin errors++; $display("FAIL t2_freeze%0d got=%b exp=%b", i, obs, E_FREEZE); end
    end
    tick; drive(1, 0, 0, 1, 1, 0); #2;
    checks++;
    if (obs !== E_BUBBLE) begin errors++; $display("FAIL t2_resp_lu got=%b exp=%b", obs, E_BUBBLE); end
    // A freeze while BUBBLED must keep the mask for the next advancing cycle.
    tick; drive(1, 0, 0, 1, 0, 1); #2;
    checks++;
    if (obs !== E_FREEZE) begin errors++; $display("FAIL t2_dwait_over_br got=%b exp=%b", obs, E_FREEZE); end
    tick; drive(1, 0, 0, 0, 0, 0); #2;
    checks++;
    if (obs !== E_RUN) begin errors++; $display("FAIL t2_held_mask got=%b exp=%b", obs, E_RUN); end
    tick; drive(0, 0, 0, 0, 0, 0); #2;
  endtask

  task automatic test_redirect;
    tick; drive(1, 0, 0, 0, 0, 1); #2;
    checks++;
    if (obs !== E_REDIR) begin errors++; $display("FAIL t3_redirect got=%b exp=%b", obs, E_REDIR); end
    tick; drive(1, 0, 0, 0, 0, 0); #2;
    checks++;
    if (obs !== E_BUBBLE) begin errors++; $display("FAIL t3_state_run got=%b exp=%b", obs, E_BUBBLE); end
    tick; drive(0, 0, 0, 0, 0, 0); #2;
  endtask

  task automatic test_branch_fetch_wait;
    for (int i = 0; i < 2; i++) begin
      tick; drive(0, 1, 0, 0, 0, 1); #2;
      checks++;
      if (obs !== E_FREEZE) begin errors++; $display("FAIL t4_freeze%0d got=%b exp=%b", i, obs, E_FREEZE); end
    end
    tick; drive(0, 1, 1, 0, 0, 1); #2;
    checks++;
    if (obs !== E_REDIR) begin errors++; $display("FAIL t4_redirect got=%b exp=%b", obs, E_REDIR); end
    tick; drive(0, 0, 0, 0, 0, 0); #2;
    checks++;
    if (obs !== E_RUN) begin errors++; $display("FAIL t4_after got=%b exp=%b", obs, E_RUN); end
  endtask

  task automatic test_fetch_wait;
    tick; drive(0, 1, 0, 0, 0, 0); #2;
    checks++;
    if (obs !== E_BUBBLE) begin errors++; $display("FAIL fw_bubble got=%b exp=%b", obs, E_BUBBLE); end
    tick; drive(1, 1, 1, 0, 0, 0); #2;
    checks++;
    if (obs !== E_BUBBLE) begin errors++; $display("FAIL fw_then_lu got=%b exp=%b", obs, E_BUBBLE); end
    tick; drive(1, 1, 0, 0, 0, 0); #2;
    checks++;
    if (obs !== E_BUBBLE) begin errors++; $display("FAIL fw_in_bubbled got=%b exp=%b", obs, E_BUBBLE); end
    tick; drive(0, 0, 0, 0, 0, 0); #2;
  endtask

  task automatic test_reset_mid_stall;
    for (int pass = 0; pass < 2; pass++) begin
      tick; drive(1, 0, 0, 0, 0, 0); #2;
      tick; drive(1, 0, 0, 0, 0, 0); #1;
      rst = 1'b1;
      #1;
      checks++;
      if (obs !== E_RESET) begin errors++; $display("FAIL t5_async%0d got=%b exp=%b", pass, obs, E_RESET); end
      tick;
      rst = 1'b0;
      if (pass == 0) drive(0, 0, 0, 0, 0, 0);
      else           drive(1, 0, 0, 0, 0, 0);
      #2;
      checks++;
      if (pass == 0 && obs !== E_RUN) begin
        errors++; $display("FAIL t5_release_idle got=%b exp=%b", obs, E_RUN);
      end else if (pass == 1 && obs !== E_BUBBLE) begin
        errors++; $display("FAIL t5_release_lu got=%b exp=%b", obs, E_BUBBLE);
      end
      tick; drive(0, 0, 0, 0, 0, 0); #2;
    end
  endtask

  task automatic test_counters;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    tick;
    rst = 1'b0;
    drive(1, 0, 0, 1, 0, 0);
    repeat (17) @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0);
    #2;
`ifdef PIPE_PERF_CNT_EN
    checks++;
    if (bus.stall_cycles !== W'(1)) begin
      errors++; $display("FAIL t6_stall_wrap got=%0d exp=1", bus.stall_cycles);
    end
`else
    checks++;
    if (bus.stall_cycles !== '0) begin
      errors++; $display("FAIL t6_stall_tied got=%0d exp=0", bus.stall_cycles);
    end
`endif
    drive(0, 0, 0, 0, 0, 1);
    repeat (2) @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0);
    #2;
`ifdef PIPE_PERF_CNT_EN
    checks++;
    if (bus.flush_count !== W'(2)) begin
      errors++; $display("FAIL t6_flush got=%0d exp=2", bus.flush_count);
    end
    checks++;
    if (bus.stall_cycles !== W'(1)) begin
      errors++; $display("FAIL t6_stall_hold got=%0d exp=1", bus.stall_cycles);
    end
`else
    checks++;
    if (bus.flush_count !== '0) begin
      errors++; $display("FAIL t6_flush_tied got=%0d exp=0", bus.flush_count);
    end
`endif
  endtask

  initial begin
    test_reset;
    test_load_use;
    test_dmem_freeze;
    test_redirect;
    test_branch_fetch_wait;
    test_fetch_wait;
    test_reset_mid_stall;
    test_counters;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
